// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path (8N1, LSB first).
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = 3;

    // Index of the last data bit in a frame; reaching it moves the FSM to STOP.
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_bit_decoder.sv
// One-hot decoder: turns the current bit index into a mask selecting the
// byte-register position that receives the sampled bit.
module uart_rx_bit_decoder
    import uart_rx_pkg::*;
(
    input  logic [BIT_IDX_W-1:0] index,
    output logic [DATA_BITS-1:0] mask
);

    // Exactly one mask bit set, at the position named by index.
    always_comb begin
        mask        = '0;
        mask[index] = 1'b1;
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronises rx, validates the start bit, samples
// each data bit mid-period and reports a framed byte or a framing error.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Start bit is checked half a bit in; data/stop bits one full bit apart.
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic [DATA_BITS-1:0]   mask;

    uart_rx_bit_decoder u_bit_decoder (
        .index (bit_idx_q),
        .mask  (mask)
    );

    // Shift the raw pin into the synchroniser chain; only the last stage is used.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Next-state, counters, byte assembly and registered-output values.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    shift_d = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = (shift_q & ~mask) | (mask & {DATA_BITS{rx_s}});
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state starts its timing from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // State, counters, synchroniser and outputs all register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchroniser resets to the idle-high line level so reset release cannot look like a start bit.
            sync_q      <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at 16 clocks per bit.
module tb_uart_rx_controller;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Monitor totals; tests compare deltas against snapshots.
    int         valid_total = 0;
    int         ferr_total  = 0;
    logic [7:0] rx_log[$];

    uart_rx_controller #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid || frame_err) begin
                check("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            end
            if (rx_valid) begin
                valid_total++;
                rx_log.push_back(rx_data);
            end
            if (frame_err) begin
                ferr_total++;
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; stop level and stop length selectable, optional busy probing mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len,
                              input logic chk_busy);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB / 2) @(negedge clk);
            if (chk_busy) check($sformatf("busy_bit%0d", k), {31'd0, busy}, 32'd1);
            repeat (CPB / 2) @(negedge clk);
        end
        rx = stop;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic expect_bytes(input string tag, input int v0, input int base,
                                input logic [7:0] exp[], input int f0);
        check({tag, "_count"}, valid_total - v0, exp.size());
        check({tag, "_ferr"}, ferr_total - f0, 32'd0);
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_log[base + i]}, {24'd0, exp[i]});
        end
    endtask

    initial begin
        int         v0, f0, base;
        logic [7:0] exp[];

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // 1: single 0xA5 frame with busy probed through every data bit.
        v0 = valid_total; f0 = ferr_total; base = rx_log.size();
        send_frame(8'hA5, 1'b1, CPB, 1'b1);
        idle(8);
        exp = new[1]; exp[0] = 8'hA5;
        expect_bytes("t1", v0, base, exp, f0);
        check("t1_rx_data", {24'd0, rx_data}, 32'h0000_00A5);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);

        // 2: back-to-back 0x00 then 0xFF, no gap.
        v0 = valid_total; f0 = ferr_total; base = rx_log.size();
        send_frame(8'h00, 1'b1, CPB, 1'b0);
        send_frame(8'hFF, 1'b1, CPB, 1'b0);
        idle(8);
        exp = new[2]; exp[0] = 8'h00; exp[1] = 8'hFF;
        expect_bytes("t2", v0, base, exp, f0);

        // 3: 5-clock glitch is rejected as a false start.
        v0 = valid_total; f0 = ferr_total;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(3);
        check("t3_busy_during_glitch", {31'd0, busy}, 32'd1);
        idle(20);
        check("t3_no_valid", valid_total - v0, 32'd0);
        check("t3_no_ferr", ferr_total - f0, 32'd0);
        check("t3_busy_idle", {31'd0, busy}, 32'd0);

        // 4: 0x3C with stop held low 40 clocks, then a clean 0x81.
        v0 = valid_total; f0 = ferr_total;
        send_frame(8'h3C, 1'b0, 30, 1'b0);
        rx = 1'b0;
        check("t4_busy_in_break", {31'd0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        check("t4_busy_still_break", {31'd0, busy}, 32'd1);
        idle(6);
        check("t4_busy_idle", {31'd0, busy}, 32'd0);
        check("t4_ferr_count", ferr_total - f0, 32'd1);
        check("t4_no_valid", valid_total - v0, 32'd0);
        check("t4_rx_data_kept", {24'd0, rx_data}, 32'h0000_00FF);
        v0 = valid_total; f0 = ferr_total; base = rx_log.size();
        send_frame(8'h81, 1'b1, CPB, 1'b0);
        idle(8);
        exp = new[1]; exp[0] = 8'h81;
        expect_bytes("t4b", v0, base, exp, f0);

        // 5: asynchronous reset during data bit 4 of 0x5A, then 0x96.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = k[0] ? 1'b1 : 1'b0;          // 0x5A bits 0..3 = 0,1,0,1
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;                            // bit 4 of 0x5A
        repeat (CPB / 2) @(negedge clk);
        check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        v0 = valid_total; f0 = ferr_total; base = rx_log.size();
        send_frame(8'h96, 1'b1, CPB, 1'b0);
        idle(8);
        exp = new[1]; exp[0] = 8'h96;
        expect_bytes("t5", v0, base, exp, f0);
        check("t5_rx_data", {24'd0, rx_data}, 32'h0000_0096);

        // 6: walking one across all decoder positions.
        v0 = valid_total; f0 = ferr_total; base = rx_log.size();
        exp = new[8];
        for (int i = 0; i < 8; i++) begin
            exp[i] = 8'h01 << i;
            send_frame(exp[i], 1'b1, CPB, 1'b0);
            idle(2);
        end
        idle(8);
        expect_bytes("t6", v0, base, exp, f0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
